divider_8: RTL

Sequential 8-bit restoring divider for the lab datapath, the inverse of the shift-add multiplier. It uses the same switch-and-button operator model: the dividend is loaded from `Din`, then `Execute` latches the divisor from `Din` and runs one quotient bit per clock. Quotient and remainder are held on the outputs for the hex-display and top-level wrapper logic.

---
 rtl/divider_8.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/divider_8.sv
// rtl/divider_8.sv - sequential 8-bit restoring divider, one quotient bit per clock
// Optional two's-complement operation when DIVIDER_SIGNED_EN is defined.
module divider_8 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       ClearA_LoadQ,
  input  logic [7:0] Din,
  output logic [7:0] Qval,
  output logic [7:0] Rval,
  output logic       Busy,
  output logic       DivZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;

  state_t     state_q;
  logic [8:0] a_q;
  logic [7:0] q_q;
  logic [7:0] d_q;
  logic [2:0] cnt_q;
  logic       busy_q;
  logic       divzero_q;
  // Execute must be seen high once after reset before a press is accepted.
  logic       armed_q;

  logic [8:0] a_d;
  logic [7:0] q_d;
  logic       fits_d;

`ifdef DIVIDER_SIGNED_EN
  logic       neg_quo_q;
  logic       neg_rem_q;
  logic [7:0] dvd_mag_d;
  logic [7:0] dvs_mag_d;

  always_comb begin
    dvd_mag_d = q_q[7] ? (~q_q + 8'd1) : q_q;
    dvs_mag_d = Din[7] ? (~Din + 8'd1) : Din;
  end
`endif

  // Shift {A,Q} left by one and try to subtract the divisor from the new A.
  always_comb begin
    fits_d = ({a_q, q_q[7]} >= {2'b00, d_q});
    if (fits_d) begin
      a_d = {a_q[7:0], q_q[7]} - {1'b0, d_q};
      q_d = {q_q[6:0], 1'b1};
    end else begin
      a_d = {a_q[7:0], q_q[7]};
      q_d = {q_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      a_q       <= 9'd0;
      q_q       <= 8'd0;
      d_q       <= 8'd0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      divzero_q <= 1'b0;
      armed_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      if (Execute) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!ClearA_LoadQ) begin
            a_q       <= 9'd0;
            q_q       <= Din;
            divzero_q <= 1'b0;
          end else if (!Execute && armed_q) begin
            if (Din == 8'd0) begin
              divzero_q <= 1'b1;
              q_q       <= 8'hFF;
              a_q       <= {1'b0, q_q};
              state_q   <= HOLD;
            end else begin
`ifdef DIVIDER_SIGNED_EN
              d_q       <= dvs_mag_d;
              q_q       <= dvd_mag_d;
              neg_quo_q <= Din[7] ^ q_q[7];
              neg_rem_q <= q_q[7];
`else
              d_q       <= Din;
`endif
              a_q       <= 9'd0;
              cnt_q     <= 3'd0;
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          a_q <= a_d;
          q_q <= q_d;
          if (cnt_q == 3'd7) begin
`ifdef DIVIDER_SIGNED_EN
            state_q <= FIX;
`else
            busy_q  <= 1'b0;
            state_q <= HOLD;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
`ifdef DIVIDER_SIGNED_EN
        FIX: begin
          if (neg_quo_q) begin
            q_q <= ~q_q + 8'd1;
          end
          if (neg_rem_q) begin
            a_q <= {1'b0, ~a_q[7:0] + 8'd1};
          end
          busy_q  <= 1'b0;
          state_q <= HOLD;
        end
`endif
        HOLD: begin
          if (Execute) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Qval    = q_q;
  assign Rval    = a_q[7:0];
  assign Busy    = busy_q;
  assign DivZero = divzero_q;

endmodule
